// File: rtl/seg_shift_out_if.sv
// Byte handshake between the display byte mux (master) and the segment serializer (slave).
interface seg_shift_out_if;
    logic [7:0] din;
    logic       din_valid;
    logic       din_ready;

    modport master (output din, output din_valid, input din_ready);
    modport slave  (input din, input din_valid, output din_ready);
endinterface

// File: rtl/seg_shift_out.sv
// Serializes segment bytes MSB-first into a 74HC595-style chain and latches after
// every FRAME_BYTES bytes.
module seg_shift_out #(
    parameter int CLK_DIV     = 2,
    parameter int FRAME_BYTES = 8
) (
    input  logic           clk,
    input  logic           rst,
    seg_shift_out_if.slave din_if,
    output logic           sclk,
    output logic           sdat,
    output logic           slat,
    output logic           busy,
    output logic           frame_done
);
    localparam int DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int BYTE_W = (FRAME_BYTES > 1) ? $clog2(FRAME_BYTES) : 1;
    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);
    localparam logic [BYTE_W-1:0] BYTE_LAST = BYTE_W'(FRAME_BYTES - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_WAIT  = 2'd2,
        ST_LATCH = 2'd3
    } state_t;

    state_t              state_r;
    logic [7:0]          shreg_r;
    logic [2:0]          bit_cnt_r;
    logic [BYTE_W-1:0]   byte_cnt_r;
    logic [DIV_W-1:0]    div_cnt_r;
    logic                sclk_r;
    logic                sdat_r;
    logic                slat_r;
    logic                busy_r;
    logic                frame_done_r;
    logic                accept_s;

    assign din_if.din_ready = ((state_r == ST_IDLE) || (state_r == ST_WAIT)) && !rst;
    assign accept_s         = din_if.din_valid && din_if.din_ready;

    assign sclk       = sclk_r;
    assign sdat       = sdat_r;
    assign slat       = slat_r;
    assign busy       = busy_r;
    assign frame_done = frame_done_r;

    // Serializer FSM: byte load, bit timing, frame counting and latch strobe.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            shreg_r      <= 8'h00;
            bit_cnt_r    <= 3'd0;
            byte_cnt_r   <= '0;
            div_cnt_r    <= '0;
            sclk_r       <= 1'b0;
            sdat_r       <= 1'b0;
            slat_r       <= 1'b0;
            busy_r       <= 1'b0;
            frame_done_r <= 1'b0;
        end else begin
            frame_done_r <= 1'b0;
            case (state_r)
                ST_IDLE, ST_WAIT: begin
                    if (accept_s) begin
                        shreg_r   <= din_if.din;
                        sdat_r    <= din_if.din[7];
                        sclk_r    <= 1'b0;
                        div_cnt_r <= '0;
                        bit_cnt_r <= 3'd0;
                        busy_r    <= 1'b1;
                        state_r   <= ST_SHIFT;
                    end else begin
                        sclk_r <= 1'b0;
                    end
                end
                ST_SHIFT: begin
                    if (div_cnt_r != DIV_LAST) begin
                        div_cnt_r <= div_cnt_r + DIV_W'(1);
                    end else begin
                        div_cnt_r <= '0;
                        if (!sclk_r) begin
                            sclk_r <= 1'b1;
                        end else begin
                            sclk_r  <= 1'b0;
                            shreg_r <= {shreg_r[6:0], 1'b0};
                            if (bit_cnt_r != 3'd7) begin
                                bit_cnt_r <= bit_cnt_r + 3'd1;
                                sdat_r    <= shreg_r[6];
                            end else begin
                                // Last bit of the byte: sdat keeps bit 0 through WAIT/LATCH.
                                bit_cnt_r <= 3'd0;
                                if (byte_cnt_r != BYTE_LAST) begin
                                    byte_cnt_r <= byte_cnt_r + BYTE_W'(1);
                                    state_r    <= ST_WAIT;
                                end else begin
                                    slat_r  <= 1'b1;
                                    state_r <= ST_LATCH;
                                end
                            end
                        end
                    end
                end
                ST_LATCH: begin
                    if (div_cnt_r != DIV_LAST) begin
                        div_cnt_r <= div_cnt_r + DIV_W'(1);
                    end else begin
                        div_cnt_r    <= '0;
                        slat_r       <= 1'b0;
                        frame_done_r <= 1'b1;
                        byte_cnt_r   <= '0;
                        busy_r       <= 1'b0;
                        state_r      <= ST_IDLE;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    sclk_r  <= 1'b0;
                    slat_r  <= 1'b0;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_seg_shift_out.sv
// Bench for seg_shift_out: two parameterizations checked cycle-by-cycle against a
// timeline model of the serial waveform, plus directed literal expectations.
module tb_seg_shift_out;
    localparam int CD_A = 2;
    localparam int FB_A = 2;
    localparam int CD_B = 1;
    localparam int FB_B = 1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    seg_shift_out_if if_a ();
    seg_shift_out_if if_b ();

    logic sclk_a, sdat_a, slat_a, busy_a, fd_a;
    logic sclk_b, sdat_b, slat_b, busy_b, fd_b;

    seg_shift_out #(.CLK_DIV(CD_A), .FRAME_BYTES(FB_A)) dut_a (
        .clk(clk), .rst(rst), .din_if(if_a),
        .sclk(sclk_a), .sdat(sdat_a), .slat(slat_a), .busy(busy_a), .frame_done(fd_a)
    );

    seg_shift_out #(.CLK_DIV(CD_B), .FRAME_BYTES(FB_B)) dut_b (
        .clk(clk), .rst(rst), .din_if(if_b),
        .sclk(sclk_b), .sdat(sdat_b), .slat(slat_b), .busy(busy_b), .frame_done(fd_b)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    bit chk_en = 1'b0;

    // stimulus values applied at the next step
    logic       rst_v = 1'b1;
    logic       va = 1'b0, vb = 1'b0;
    logic [7:0] da = 8'h00, db = 8'h00;

    // model state per instance: last accepted byte, its cycle, its index in the frame
    int         cdv [2];
    int         fbv [2];
    bit         m_active [2];
    int         m_acc [2];
    int         m_idx [2];
    logic [7:0] m_byte [2];
    logic       m_hold [2];
    bit         acc_now [2];
    logic       prev_sclk [2];

    int acc_q0[$], acc_q1[$], slat_q0[$], slat_q1[$], fd_q0[$], fd_q1[$], risec_q1[$];
    bit rise_q0[$], rise_q1[$];

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic compare();
        for (int d = 0; d < 2; d++) begin
            logic [5:0] got_v, exp_v;
            logic       vld;
            logic [7:0] dv;
            int         o, per;
            if (d == 0) begin
                got_v = {sclk_a, sdat_a, slat_a, busy_a, fd_a, if_a.din_ready};
                vld = if_a.din_valid; dv = if_a.din;
            end else begin
                got_v = {sclk_b, sdat_b, slat_b, busy_b, fd_b, if_b.din_ready};
                vld = if_b.din_valid; dv = if_b.din;
            end
            per = 2 * cdv[d];
            exp_v = {1'b0, m_hold[d], 1'b0, 1'b0, 1'b0, 1'b1};
            if (m_active[d]) begin
                o = cyc - m_acc[d] - 1;
                if (o < 8 * per) begin
                    exp_v = {((o % per) >= cdv[d]), m_byte[d][7 - o / per], 1'b0, 1'b1, 1'b0, 1'b0};
                end else if (m_idx[d] < fbv[d] - 1) begin
                    exp_v = {1'b0, m_byte[d][0], 1'b0, 1'b1, 1'b0, 1'b1};
                end else if (o < 8 * per + cdv[d]) begin
                    exp_v = {1'b0, m_byte[d][0], 1'b1, 1'b1, 1'b0, 1'b0};
                end else begin
                    exp_v = {1'b0, m_byte[d][0], 1'b0, 1'b0, 1'b1, 1'b1};
                    m_active[d] = 1'b0;
                    m_hold[d]   = m_byte[d][0];
                end
            end
            if (rst) exp_v[0] = 1'b0;
            checks++;
            if (got_v !== exp_v) begin
                errors++;
                $display("FAIL outputs dut%0d cyc=%0d got=%b exp=%b (sclk,sdat,slat,busy,frame_done,din_ready)",
                         d, cyc, got_v, exp_v);
            end
            acc_now[d] = !rst && vld && exp_v[0];
            if (acc_now[d]) begin
                m_idx[d]    = m_active[d] ? m_idx[d] + 1 : 0;
                m_active[d] = 1'b1;
                m_acc[d]    = cyc;
                m_byte[d]   = dv;
                if (d == 0) acc_q0.push_back(cyc); else acc_q1.push_back(cyc);
            end
            if (rst) begin
                m_active[d] = 1'b0;
                m_hold[d]   = 1'b0;
            end
            if (got_v[5] && !prev_sclk[d]) begin
                if (d == 0) rise_q0.push_back(got_v[4]);
                else begin rise_q1.push_back(got_v[4]); risec_q1.push_back(cyc); end
            end
            prev_sclk[d] = got_v[5];
            if (got_v[3]) begin if (d == 0) slat_q0.push_back(cyc); else slat_q1.push_back(cyc); end
            if (got_v[1]) begin if (d == 0) fd_q0.push_back(cyc); else fd_q1.push_back(cyc); end
        end
    endtask

    task automatic step();
        @(posedge clk);
        cyc++;
        #1;
        rst = rst_v;
        if_a.din_valid = va; if_a.din = da;
        if_b.din_valid = vb; if_b.din = db;
        @(negedge clk);
        if (chk_en) compare();
    endtask

    task automatic send(input int d, input logic [7:0] b, input int budget);
        bit got = 1'b0;
        if (d == 0) begin da = b; va = 1'b1; end else begin db = b; vb = 1'b1; end
        for (int i = 0; i < budget; i++) begin
            step();
            if (acc_now[d]) begin got = 1'b1; break; end
        end
        if (d == 0) va = 1'b0; else vb = 1'b0;
        chk("send accepted", got, 1);
    endtask

    task automatic wait_fd(input int d, input int budget);
        int n0 = (d == 0) ? fd_q0.size() : fd_q1.size();
        bit seen = 1'b0;
        for (int i = 0; i < budget; i++) begin
            step();
            if (((d == 0) ? fd_q0.size() : fd_q1.size()) > n0) begin seen = 1'b1; break; end
        end
        chk("frame_done within budget", seen, 1);
    endtask

    function automatic int rise_bits(input int d, input int n, input int k);
        int v = 0;
        for (int i = 0; i < k; i++) begin
            if (d == 0) v = (v << 1) | ((n + i < rise_q0.size()) ? int'(rise_q0[n + i]) : 0);
            else        v = (v << 1) | ((n + i < rise_q1.size()) ? int'(rise_q1[n + i]) : 0);
        end
        return v;
    endfunction

    initial begin
        int na, ns, nf, nr, t0;
        cdv[0] = CD_A; cdv[1] = CD_B; fbv[0] = FB_A; fbv[1] = FB_B;
        for (int d = 0; d < 2; d++) begin
            m_active[d] = 1'b0; m_acc[d] = 0; m_idx[d] = 0; m_byte[d] = 8'h00;
            m_hold[d] = 1'b0; acc_now[d] = 1'b0; prev_sclk[d] = 1'b0;
        end
        rst = 1'b1;
        if_a.din_valid = 1'b0; if_a.din = 8'h00; if_b.din_valid = 1'b0; if_b.din = 8'h00;
        step();
        chk_en = 1'b1;

        // reset held with valid asserted
        va = 1'b1; vb = 1'b1; da = 8'hA5; db = 8'h81;
        for (int i = 0; i < 3; i++) step();
        chk("reset sclk", sclk_a, 0); chk("reset slat", slat_a, 0);
        chk("reset busy", busy_a, 0); chk("reset ready", if_a.din_ready, 0);
        va = 1'b0; vb = 1'b0; rst_v = 1'b0;
        step();
        chk("ready after release", if_a.din_ready, 1);
        step();

        // two-byte frame with valid held
        na = acc_q0.size(); ns = slat_q0.size(); nf = fd_q0.size(); nr = rise_q0.size();
        send(0, 8'hA5, 10);
        send(0, 8'h3C, 60);
        wait_fd(0, 100);
        chk("frame bits", rise_bits(0, nr, 16), 16'hA53C);
        chk("accept gap", (acc_q0.size() > na + 1) ? acc_q0[na + 1] - acc_q0[na] : -1, 33);
        chk("slat cycles", slat_q0.size() - ns, 2);
        chk("slat start", (slat_q0.size() > ns) ? slat_q0[ns] - acc_q0[na] : -1, 66);
        chk("frame_done count", fd_q0.size() - nf, 1);
        chk("frame_done time", (fd_q0.size() > nf) ? fd_q0[nf] - acc_q0[na] : -1, 68);
        step();

        // upstream stall in WAIT
        ns = slat_q0.size(); nf = fd_q0.size(); nr = rise_q0.size();
        send(0, 8'hA5, 10);
        for (int i = 0; i < 60; i++) step();
        chk("stall sclk", sclk_a, 0); chk("stall sdat", sdat_a, 1); chk("stall busy", busy_a, 1);
        send(0, 8'h3C, 10);
        wait_fd(0, 100);
        chk("stall bits", rise_bits(0, nr, 16), 16'hA53C);
        chk("stall latch", slat_q0.size() - ns, 2);
        chk("stall frame_done", fd_q0.size() - nf, 1);

        // input isolation on the single-byte instance
        nr = rise_q1.size();
        send(1, 8'hFF, 10);
        db = 8'h00;
        wait_fd(1, 40);
        chk("isolation bits", rise_bits(1, nr, 8), 8'hFF);

        // CLK_DIV=1, FRAME_BYTES=1 corner
        na = acc_q1.size(); ns = slat_q1.size(); nf = fd_q1.size(); nr = rise_q1.size();
        send(1, 8'h81, 10);
        wait_fd(1, 40);
        chk("corner bits", rise_bits(1, nr, 8), 8'h81);
        chk("corner rises", rise_q1.size() - nr, 8);
        chk("corner sclk period", (risec_q1.size() > nr + 1) ? risec_q1[nr + 1] - risec_q1[nr] : -1, 2);
        chk("corner slat", slat_q1.size() - ns, 1);
        chk("corner frame_done", (fd_q1.size() > nf) ? fd_q1[nf] - acc_q1[na] : -1, 18);

        // mid-frame abort during byte 1, bit 3
        ns = slat_q0.size(); nf = fd_q0.size();
        send(0, 8'h12, 10);
        send(0, 8'h34, 60);
        for (int i = 0; i < 13; i++) step();
        rst_v = 1'b1; step(); step(); rst_v = 1'b0;
        for (int i = 0; i < 40; i++) step();
        chk("abort no slat", slat_q0.size() - ns, 0);
        chk("abort no frame_done", fd_q0.size() - nf, 0);
        ns = slat_q0.size(); nf = fd_q0.size(); nr = rise_q0.size();
        send(0, 8'h56, 10);
        send(0, 8'h78, 60);
        wait_fd(0, 100);
        chk("after abort rises", rise_q0.size() - nr, 16);
        chk("after abort bits", rise_bits(0, nr, 16), 16'h5678);
        chk("after abort latch", slat_q0.size() - ns, 2);
        chk("after abort frame_done", fd_q0.size() - nf, 1);

        // randomized traffic with occasional resets
        for (int i = 0; i < 3000; i++) begin
            va = 1'($urandom_range(0, 1)); vb = 1'($urandom_range(0, 1));
            da = 8'($urandom); db = 8'($urandom);
            rst_v = ($urandom_range(0, 399) == 0);
            step();
        end
        rst_v = 1'b0; va = 1'b0; vb = 1'b0;
        for (int i = 0; i < 100; i++) step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
